// File: rtl/s27_pkg.sv
// Shared types and the s27 next-state/output function used by every channel.
package s27_pkg;

  localparam logic [15:0] MISR_POLY_DEFAULT = 16'h1021;

  typedef struct packed {
    logic s5;
    logic s6;
    logic s7;
  } s27_state_t;

  typedef struct packed {
    s27_state_t next_state;
    logic       g17;
  } s27_step_t;

  // g_in = {G3,G2,G1,G0}; the network is loop-free so this is pure logic.
  function automatic s27_step_t s27_next(input s27_state_t st, input logic [3:0] g_in);
    s27_step_t res;
    logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
    g14 = ~g_in[0];
    g8  = g14 & st.s6;
    g12 = ~(g_in[1] | st.s7);
    g15 = g12 | g8;
    g16 = g_in[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(st.s5 | g9);
    g10 = ~(g14 | g11);
    g13 = ~(g_in[2] | g12);
    res.next_state.s5 = g10;
    res.next_state.s6 = g11;
    res.next_state.s7 = g13;
    res.g17 = ~g11;
    return res;
  endfunction

endpackage

// File: rtl/s27_core.sv
// One s27 channel: three mux-D scan flops (S5 -> S6 -> S7) plus the s27 logic.
module s27_core
  import s27_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       SE,
  input  logic       SCAN_IN,
  output logic       SCAN_OUT,
  input  logic [3:0] G_IN,
  output logic       G17
);

  s27_state_t state;
  s27_state_t state_next;
  s27_step_t  step;

  always_comb begin
    step       = s27_next(state, G_IN);
    state_next = step.next_state;
    if (SE) begin
      state_next.s5 = SCAN_IN;
      state_next.s6 = state.s5;
      state_next.s7 = state.s6;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= '0;
    else     state <= state_next;
  end

  // G17 stays live during shift; SCAN_OUT is the raw S7 flop.
  assign G17      = step.g17;
  assign SCAN_OUT = state.s7;

endmodule

// File: rtl/s27_scan_array.sv
// N_CH s27 channels on one scan chain, with a Galois MISR compacting G_OUT
// and a saturating count of MISR updates.
module s27_scan_array
  import s27_pkg::*;
#(
  parameter int                N_CH      = 4,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(MISR_POLY_DEFAULT),
  parameter int                CNT_W     = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [4*N_CH-1:0]   G_IN,
  output logic [N_CH-1:0]     G_OUT,
  input  logic                SE,
  input  logic                SI,
  output logic                SO,
  input  logic                MISR_EN,
  output logic [MISR_W-1:0]   MISR_SIG,
  output logic [CNT_W-1:0]    CAP_CNT
);

  if (N_CH > MISR_W || N_CH < 1) begin : g_bad_cfg
    $fatal(1, "s27_scan_array: N_CH must be in 1..MISR_W");
  end

  logic [N_CH:0]     chain;
  logic [MISR_W-1:0] g_ext;
  logic              misr_upd;

  assign chain[0] = SI;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    s27_core u_core (
      .CLK      (CLK),
      .RST      (RST),
      .SE       (SE),
      .SCAN_IN  (chain[c]),
      .SCAN_OUT (chain[c+1]),
      .G_IN     (G_IN[4*c +: 4]),
      .G17      (G_OUT[c])
    );
  end

  assign SO = chain[N_CH];

  always_comb begin
    g_ext             = '0;
    g_ext[N_CH-1:0]   = G_OUT;
  end

  // Shift has priority over compaction: SE freezes both MISR and counter.
  assign misr_upd = MISR_EN & ~SE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      MISR_SIG <= '0;
      CAP_CNT  <= '0;
    end else if (misr_upd) begin
      MISR_SIG <= {MISR_SIG[MISR_W-2:0], 1'b0}
                ^ (MISR_SIG[MISR_W-1] ? MISR_POLY : '0)
                ^ g_ext;
      if (CAP_CNT != '1) CAP_CNT <= CAP_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_s27_scan_array.sv
// Directed and randomized checks of s27_scan_array against a bit-vector model.
module tb_s27_scan_array;

  localparam int N_CH = 4;
  localparam int CH   = 3 * N_CH;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, se, si, misr_en;
  logic [4*N_CH-1:0] g_in;
  logic [N_CH-1:0]   g_out, g_out4;
  logic              so, so4;
  logic [15:0]       misr_sig, misr_sig4;
  logic [15:0]       cap_cnt;
  logic [3:0]        cap_cnt4;

  s27_scan_array dut (
    .CLK(clk), .RST(rst), .G_IN(g_in), .G_OUT(g_out), .SE(se), .SI(si),
    .SO(so), .MISR_EN(misr_en), .MISR_SIG(misr_sig), .CAP_CNT(cap_cnt)
  );

  s27_scan_array #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .G_IN(g_in), .G_OUT(g_out4), .SE(se), .SI(si),
    .SO(so4), .MISR_EN(misr_en), .MISR_SIG(misr_sig4), .CAP_CNT(cap_cnt4)
  );

  int checks = 0;
  int errors = 0;

  // reference model: chain bit 3c+0/1/2 = channel c S5/S6/S7
  logic [CH-1:0] m_chain;
  logic [15:0]   m_misr;
  int            m_cnt;
  int            m_cnt4;
  logic [0:0]    exp_q[$];

  function automatic logic [3:0] ref_eval(input logic s5, s6, s7, input logic [3:0] g);
    logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
    g14 = !g[0];
    g8  = g14 && s6;
    g12 = !(g[1] || s7);
    g15 = g12 || g8;
    g16 = g[3] || g8;
    g9  = !(g16 && g15);
    g11 = !(s5 || g9);
    g10 = !(g14 || g11);
    g13 = !(g[2] || g12);
    return {g10, g11, g13, !g11};
  endfunction

  function automatic logic [N_CH-1:0] ref_gout(input logic [CH-1:0] ch, input logic [4*N_CH-1:0] g);
    logic [N_CH-1:0] o;
    logic [3:0] r;
    for (int c = 0; c < N_CH; c++) begin
      r = ref_eval(ch[3*c], ch[3*c+1], ch[3*c+2], g[4*c +: 4]);
      o[c] = r[0];
    end
    return o;
  endfunction

  task automatic model_step(input logic r, s, sin, me);
    logic [CH-1:0] nxt;
    logic [3:0] ev;
    logic [N_CH-1:0] go;
    if (r) begin
      m_chain = '0; m_misr = '0; m_cnt = 0; m_cnt4 = 0;
    end else if (s) begin
      m_chain = {m_chain[CH-2:0], sin};
    end else begin
      go = ref_gout(m_chain, g_in);
      for (int c = 0; c < N_CH; c++) begin
        ev = ref_eval(m_chain[3*c], m_chain[3*c+1], m_chain[3*c+2], g_in[4*c +: 4]);
        nxt[3*c]   = ev[3];
        nxt[3*c+1] = ev[2];
        nxt[3*c+2] = ev[1];
      end
      m_chain = nxt;
      if (me) begin
        m_misr = {m_misr[14:0], 1'b0} ^ (m_misr[15] ? 16'h1021 : 16'h0000) ^ {12'h000, go};
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs, check G_OUT before the edge, clock, check state after
  task automatic cycle(input logic r, input logic s, input logic sin, input logic me);
    rst = r; se = s; si = sin; misr_en = me;
    #1;
    if (!r) check("g_out", 32'(g_out), 32'(ref_gout(m_chain, g_in)));
    model_step(r, s, sin, me);
    @(posedge clk);
    #1;
    check("so", 32'(so), 32'(m_chain[CH-1]));
    check("misr", 32'(misr_sig), 32'(m_misr));
    check("cnt", 32'(cap_cnt), 32'(m_cnt));
    check("cnt4", 32'(cap_cnt4), 32'(m_cnt4));
    check("misr4", 32'(misr_sig4), 32'(m_misr));
  endtask

  initial begin
    logic [CH-1:0] pat;
    logic [15:0]   saved_misr;
    int            saved_cnt;
    rst = 1'b1; se = 1'b0; si = 1'b0; misr_en = 1'b0; g_in = '0;
    m_chain = '0; m_misr = '0; m_cnt = 0; m_cnt4 = 0;

    // reset state
    cycle(1, 0, 0, 0);
    check("rst_so", 32'(so), 32'h0);
    check("rst_misr", 32'(misr_sig), 32'h0);
    check("rst_cnt", 32'(cap_cnt), 32'h0);

    // all-zero inputs, two compaction cycles
    cycle(0, 0, 0, 1);
    check("misr_c1", 32'(misr_sig), 32'h000F);
    check("gout_c1", 32'(g_out), 32'hF);
    cycle(0, 0, 0, 1);
    check("misr_c2", 32'(misr_sig), 32'h0011);
    check("cnt_c2", 32'(cap_cnt), 32'd2);

    // G0=1 on every channel: each channel captures {1,0,0}
    cycle(1, 0, 0, 0);
    g_in = 16'h1111;
    cycle(0, 0, 0, 0);
    check("g0_gout", 32'(g_out), 32'hF);
    g_in = '0;
    pat = 12'h249;
    for (int k = 1; k <= CH; k++) begin
      cycle(0, 1, 0, 0);
      if (k < CH) check("g0_scan", 32'(so), 32'(pat[CH-1-k]));
    end

    // single 1 through the chain: appears after exactly 3*N_CH edges
    cycle(1, 0, 0, 0);
    for (int k = 1; k <= CH; k++) begin
      cycle(0, 1, (k == 1), 0);
      check("latency", 32'(so), 32'(k == CH));
    end

    // build a nonzero signature, then shift 12'hA5C through with MISR_EN held
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      g_in = 16'($urandom);
      cycle(0, 0, 0, 1);
    end
    saved_misr = misr_sig;
    saved_cnt  = m_cnt;
    pat = 12'hA5C;
    for (int k = CH - 1; k >= 0; k--) begin
      exp_q.push_back(pat[k]);
      g_in = 16'($urandom);
      cycle(0, 1, pat[k], 0);
    end
    for (int k = 0; k < CH; k++) begin
      check("shift_out", 32'(so), 32'(exp_q.pop_front()));
      g_in = 16'($urandom);
      cycle(0, 1, 0, 1);
      check("shift_misr_hold", 32'(misr_sig), 32'(saved_misr));
      check("shift_cnt_hold", 32'(cap_cnt), 32'(saved_cnt));
    end

    // narrow counter saturates at 15
    cycle(1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      g_in = 16'($urandom);
      cycle(0, 0, 0, 1);
      check("cnt4_sat", 32'(cap_cnt4), 32'((k < 15) ? k : 15));
    end

    // reset in the middle of a shift, then a full reshift
    for (int k = 0; k < 5; k++) cycle(0, 1, 1, 0);
    cycle(1, 1, 1, 1);
    check("midrst_so", 32'(so), 32'h0);
    check("midrst_misr", 32'(misr_sig), 32'h0);
    check("midrst_cnt", 32'(cap_cnt), 32'h0);
    for (int k = 0; k < CH; k++) begin
      si = 1'($urandom_range(0, 1));
      exp_q.push_back(si);
      cycle(0, 1, si, 0);
      if (k < CH - 1) check("reshift_zero", 32'(so), 32'h0);
    end
    for (int k = 0; k < CH; k++) begin
      check("reshift_out", 32'(so), 32'(exp_q.pop_front()));
      cycle(0, 1, 0, 0);
    end

    // randomized mix of all modes
    for (int k = 0; k < 400; k++) begin
      g_in = 16'($urandom);
      cycle(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
